// File: rtl/core_bus_xbar.sv
// core_bus_xbar: N-master x M-slave crossbar on the req/gnt/rvalid core bus.
//
// Each master address is decoded combinationally against the inclusive
// [START_ADDR, END_ADDR] slave windows. The lowest slave index wins on overlap.
// Each slave has its own round-robin arbiter, and the grant is issued in the
// same cycle as the request. The response (rvalid/rdata/err) comes exactly one
// cycle after the grant. An unmapped address is granted immediately and
// answered with err=1.
//
// Optional build macro XBAR_PERF_CNT_EN adds per-master saturating stall
// counters (perf_stall_o) and a synchronous clear input (perf_clr_i).
module core_bus_xbar #(
    parameter int NB_MASTER      = 2,
    parameter int NB_SLAVE       = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SLV_ADDR_WIDTH = 16,
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] START_ADDR =
        {32'h4000_0000, 32'h2000_0000, 32'h1000_0000},
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] END_ADDR =
        {32'h4000_0fff, 32'h2000_ffff, 32'h1000_ffff}
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NB_MASTER-1:0]                m_req_i,
    output logic [NB_MASTER-1:0]                m_gnt_o,
    output logic [NB_MASTER-1:0]                m_rvalid_o,
    output logic [NB_MASTER-1:0]                m_err_o,
    input  logic [NB_MASTER-1:0]                m_we_i,
    input  logic [NB_MASTER*DATA_WIDTH/8-1:0]   m_be_i,
    input  logic [NB_MASTER*ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [NB_MASTER*DATA_WIDTH-1:0]     m_wdata_i,
    output logic [NB_MASTER*DATA_WIDTH-1:0]     m_rdata_o,
    output logic [NB_SLAVE-1:0]                 s_req_o,
    output logic [NB_SLAVE-1:0]                 s_we_o,
    output logic [NB_SLAVE*DATA_WIDTH/8-1:0]    s_be_o,
    output logic [NB_SLAVE*SLV_ADDR_WIDTH-1:0]  s_addr_o,
    output logic [NB_SLAVE*DATA_WIDTH-1:0]      s_wdata_o,
    input  logic [NB_SLAVE*DATA_WIDTH-1:0]      s_rdata_i
`ifdef XBAR_PERF_CNT_EN
    ,
    input  logic                                perf_clr_i,
    output logic [NB_MASTER*32-1:0]             perf_stall_o
`endif
);

    localparam int BW  = DATA_WIDTH / 8;
    localparam int MW  = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int MW1 = MW + 1;
    localparam int SW  = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;

    // Unpacked views of the packed master/slave buses
    logic [ADDR_WIDTH-1:0] m_addr  [NB_MASTER];
    logic [DATA_WIDTH-1:0] m_wdata [NB_MASTER];
    logic [BW-1:0]         m_be    [NB_MASTER];
    logic [SW-1:0]         dec_slv [NB_MASTER];
    logic [NB_MASTER-1:0]  dec_miss;
    logic [NB_MASTER-1:0]  slv_oh  [NB_SLAVE];   // one-hot winner per slave
    logic [DATA_WIDTH-1:0] s_rdata [NB_SLAVE];

    genvar gi;

    // ------------------------------------------------------------------
    // Per-slave arbitration and slave-side drive
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NB_SLAVE; gi++) begin : g_slv
            logic [NB_MASTER-1:0]   reqs_c;
            logic [2*NB_MASTER-1:0] dbl_c;
            logic [NB_MASTER-1:0]   rot_c;
            logic [MW1-1:0]         sum_c;
            logic                   win_vld_c;
            logic [MW-1:0]          win_c;
            logic [NB_MASTER-1:0]   oh_c;
            logic [MW-1:0]          rr_q, rr_d;
            logic                   s_req_c, s_we_c;
            logic [BW-1:0]          s_be_c;
            logic [ADDR_WIDTH-1:0]  offs_c;
            logic [DATA_WIDTH-1:0]  s_wdata_c;

            assign s_rdata[gi] = s_rdata_i[gi*DATA_WIDTH +: DATA_WIDTH];

            // Collect the masters whose decoded target is this slave
            always_comb begin
                reqs_c = '0;
                for (int j = 0; j < NB_MASTER; j++) begin
                    reqs_c[j] = m_req_i[j] && !rst && !dec_miss[j] &&
                                (dec_slv[j] == SW'(gi));
                end
            end

            // Round-robin pick: rotate so rr_q is bit 0, take the first set bit
            always_comb begin
                dbl_c     = {reqs_c, reqs_c} >> rr_q;
                rot_c     = dbl_c[NB_MASTER-1:0];
                win_vld_c = 1'b0;
                win_c     = '0;
                sum_c     = '0;
                for (int off = 0; off < NB_MASTER; off++) begin
                    if (!win_vld_c && rot_c[off]) begin
                        win_vld_c = 1'b1;
                        sum_c = {1'b0, rr_q} + MW1'(off);
                        if (sum_c >= MW1'(NB_MASTER)) begin
                            sum_c = sum_c - MW1'(NB_MASTER);
                        end
                        win_c = sum_c[MW-1:0];
                    end
                end
                oh_c = '0;
                rr_d = rr_q;
                if (win_vld_c) begin
                    oh_c[win_c] = 1'b1;
                    rr_d = (int'(win_c) == NB_MASTER - 1) ? '0 : win_c + 1'b1;
                end
            end

            assign slv_oh[gi] = oh_c;

            // Pointer moves past the winner only when a grant happens
            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_q <= '0;
                end else begin
                    rr_q <= rr_d;
                end
            end

            // Route the winning master's command to the slave, zeros when idle
            always_comb begin
                s_req_c   = 1'b0;
                s_we_c    = 1'b0;
                s_be_c    = '0;
                offs_c    = '0;
                s_wdata_c = '0;
                if (win_vld_c) begin
                    s_req_c   = 1'b1;
                    s_we_c    = m_we_i[win_c];
                    s_be_c    = m_be[win_c];
                    offs_c    = m_addr[win_c] - START_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
                    s_wdata_c = m_wdata[win_c];
                end
            end

            assign s_req_o[gi]                                   = s_req_c;
            assign s_we_o[gi]                                    = s_we_c;
            assign s_be_o[gi*BW +: BW]                           = s_be_c;
            assign s_addr_o[gi*SLV_ADDR_WIDTH +: SLV_ADDR_WIDTH] = offs_c[SLV_ADDR_WIDTH-1:0];
            assign s_wdata_o[gi*DATA_WIDTH +: DATA_WIDTH]        = s_wdata_c;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-master decode, grant, pending tracking and response
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NB_MASTER; gi++) begin : g_mst
            logic [SW-1:0]         slv_c;
            logic                  miss_c;
            logic                  gnt_c;
            logic                  pend_vld_q, pend_miss_q, pend_we_q;
            logic [SW-1:0]         pend_slv_q;
            logic                  rvalid_c;
            logic [DATA_WIDTH-1:0] rdata_c;

            assign m_addr[gi]  = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign m_wdata[gi] = m_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign m_be[gi]    = m_be_i[gi*BW +: BW];

            // Address decode; scanning downward lets the lowest slave win overlaps
            always_comb begin
                miss_c = 1'b1;
                slv_c  = '0;
                for (int k = NB_SLAVE - 1; k >= 0; k--) begin
                    if (m_addr[gi] >= START_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH] &&
                        m_addr[gi] <= END_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                        miss_c = 1'b0;
                        slv_c  = SW'(k);
                    end
                end
            end

            assign dec_slv[gi]  = slv_c;
            assign dec_miss[gi] = miss_c;

            // Grant: misses bypass arbitration, hits take their slave's verdict
            always_comb begin
                gnt_c = m_req_i[gi] && !rst && miss_c;
                for (int k = 0; k < NB_SLAVE; k++) begin
                    if (slv_oh[k][gi]) begin
                        gnt_c = 1'b1;
                    end
                end
            end

            assign m_gnt_o[gi] = gnt_c;

            // Remember what was granted so the next cycle can return it
            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_vld_q  <= 1'b0;
                    pend_miss_q <= 1'b0;
                    pend_we_q   <= 1'b0;
                    pend_slv_q  <= '0;
                end else begin
                    pend_vld_q  <= gnt_c;
                    pend_miss_q <= miss_c;
                    pend_we_q   <= m_we_i[gi];
                    pend_slv_q  <= slv_c;
                end
            end

            // Response; reset also squashes a response due in the reset cycle
            always_comb begin
                rvalid_c = pend_vld_q && !rst;
                rdata_c  = '0;
                if (rvalid_c && !pend_miss_q && !pend_we_q) begin
                    rdata_c = s_rdata[pend_slv_q];
                end
            end

            assign m_rvalid_o[gi]                         = rvalid_c;
            assign m_err_o[gi]                            = rvalid_c && pend_miss_q;
            assign m_rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_c;

`ifdef XBAR_PERF_CNT_EN
            logic [31:0] stall_q;

            // Saturating count of cycles spent requesting without a grant
            always_ff @(posedge clk) begin
                if (rst || perf_clr_i) begin
                    stall_q <= '0;
                end else if (m_req_i[gi] && !gnt_c && (stall_q != 32'hFFFF_FFFF)) begin
                    stall_q <= stall_q + 32'd1;
                end
            end

            assign perf_stall_o[gi*32 +: 32] = stall_q;
`endif
        end
    endgenerate

endmodule

// File: doc/core_bus_xbar.md
Name: core_bus_xbar

Overview:
Parametrised N-master x M-slave crossbar on the core-native req/gnt/rvalid protocol. It replaces fixed point-to-point memory hookups with a decoded, arbitrated fabric.
- Masters are core fetch, core LSU and future DMA/debug ports.
- Slaves are single-port SRAM-style targets: instr mem, data mem, UART, and more.
- Adds per-slave round-robin arbitration and an error response for unmapped addresses.

Parameters:
NB_MASTER, 2, number of master ports (1..8)
NB_SLAVE, 3, number of slave ports (1..8)
ADDR_WIDTH, 32, master address width
DATA_WIDTH, 32, data width (multiple of 8)
SLV_ADDR_WIDTH, 16, offset width driven to each slave
START_ADDR, {32'h4000_0000,32'h2000_0000,32'h1000_0000}, packed NB_SLAVE*ADDR_WIDTH region bases; slave 0 in LSBs
END_ADDR, {32'h4000_0fff,32'h2000_ffff,32'h1000_ffff}, packed inclusive region ends

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_req_i  in  NB_MASTER  master request
m_gnt_o  out  NB_MASTER  request accepted this cycle
m_rvalid_o  out  NB_MASTER  response valid
m_err_o  out  NB_MASTER  response is decode error (qualified by rvalid)
m_we_i  in  NB_MASTER  write enable
m_be_i  in  NB_MASTER*DATA_WIDTH/8  byte enables
m_addr_i  in  NB_MASTER*ADDR_WIDTH  byte address
m_wdata_i  in  NB_MASTER*DATA_WIDTH  write data
m_rdata_o  out  NB_MASTER*DATA_WIDTH  read data
s_req_o  out  NB_SLAVE  slave access strobe
s_we_o  out  NB_SLAVE  slave write enable
s_be_o  out  NB_SLAVE*DATA_WIDTH/8  slave byte enables
s_addr_o  out  NB_SLAVE*SLV_ADDR_WIDTH  addr minus START_ADDR, truncated to SLV_ADDR_WIDTH
s_wdata_o  out  NB_SLAVE*DATA_WIDTH  slave write data
s_rdata_i  in  NB_SLAVE*DATA_WIDTH  slave read data, valid 1 cycle after s_req_o

Behaviour:
- Decode is combinational per master: hit on slave k when START_ADDR[k] <= addr <= END_ADDR[k]. On overlap the lowest k wins. No hit = miss.
- Per-slave round-robin arbiter over masters requesting it:
  - Pointer rr_q[k] resets to 0, so master 0 has top priority.
  - After a grant to master i, rr_q[k] = (i+1) mod NB_MASTER.
  - rr_q only updates on a grant.
- Grant is same-cycle: m_gnt_o[i]=1 in the cycle m_req_i[i]=1 and master i wins its slave. The slave then sees s_req_o, s_we_o, s_be_o, s_addr_o and s_wdata_o in that same cycle from master i.
- A miss is granted the same cycle with no arbitration and drives no slave.
- Response arrives exactly 1 cycle after gnt, for reads and writes alike:
  - m_rvalid_o[i]=1.
  - m_rdata_o = s_rdata_i[k] for reads; 0 for writes and misses.
  - m_err_o[i]=1 only for a miss.
- Pending state per master: valid bit plus slave index plus miss flag, registered at grant.
- A master may re-request in its rvalid cycle, giving full throughput of one transfer per cycle per master.
- A master holds req/addr/we/be/wdata stable until gnt. A losing master waits with no timeout.
- Different masters on different slaves proceed in parallel in the same cycle.
- Idle slave: s_req_o=0; other s_* outputs are don't-care but driven to 0.
- Reset, applied synchronously at any time:
  - Clears all pending entries; in-flight responses are dropped, so no rvalid in the cycle after reset.
  - rr_q = 0.
  - Outputs m_gnt_o, m_rvalid_o, m_err_o, s_req_o = 0; m_rdata_o = 0.
- While rst=1, no grants are issued even if req=1.

Optional Feature:
XBAR_PERF_CNT_EN:
- Defined: adds output perf_stall_o, NB_MASTER*32 bits. Per master, a 32-bit counter increments each cycle m_req_i=1 && m_gnt_o=0, and saturates at 32'hFFFF_FFFF.
- Adds input perf_clr_i, 1 bit: synchronous clear of all counters; it has priority over increment.
- rst clears all counters.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
1. Master 0 writes 32'hDEAD_BEEF, be=4'hF, to 32'h2000_0010 -> gnt same cycle; s_req_o[1]=1 with s_addr_o=16'h0010. Next cycle rvalid=1, err=0, rdata=0.
2. Master 1 reads 32'h1000_0004 while slave 0 returns 32'h1234_5678 -> s_addr_o[0]=16'h0004; next cycle m_rdata_o[1]=32'h1234_5678.
3. Both masters request slave 1 continuously for 4 cycles from reset -> grants alternate M0,M1,M0,M1; each loser's stall cycle is visible.
4. Master 0 reads 32'h3000_0000 (unmapped) -> gnt same cycle, no s_req_o. Next cycle rvalid=1, err=1, rdata=0.
5. M0 hits slave 0 and M1 hits slave 2 (32'h4000_0100) in the same cycle -> both granted; s_addr_o[2]=16'h0100.
6. rst asserted in the cycle after a granted read -> no rvalid follows, rr_q returns to 0, and the next contended grant goes to M0. With XBAR_PERF_CNT_EN, the stall counter equals the counted wait cycles, then 0 after perf_clr_i.
